// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types and sizing helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_t;

    // One register stage per shift-amount bit.
    function automatic int stage_count(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One registered barrel-shifter stage: shifts by 2^K when shamt bit K is set.
module barrel_shift_stage
    import shifter_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = $clog2(N),
    parameter int K  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          d_vld,
    input  logic [N-1:0]  d_data,
    input  logic [SW-1:0] d_shamt,
    input  shift_dir_t    d_dir,
    input  logic          d_arith,
    output logic          q_vld,
    output logic [N-1:0]  q_data,
    output logic [SW-1:0] q_shamt,
    output shift_dir_t    q_dir,
    output logic          q_arith
);

    localparam int S = 1 << K;

    logic         fill;
    logic [N-1:0] shifted;

    // The MSB never changes across stages, so per-stage sign fill composes
    // into a full arithmetic shift.
    assign fill = d_arith & d_data[N-1];

    always_comb begin
        shifted = d_data;
        if (d_shamt[K]) begin
            if (d_dir == SHIFT_RIGHT) shifted = {{S{fill}}, d_data[N-1:S]};
            else                      shifted = {d_data[N-1-S:0], {S{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld   <= 1'b0;
            q_data  <= '0;
            q_shamt <= '0;
            q_dir   <= SHIFT_LEFT;
            q_arith <= 1'b0;
        end else if (en) begin
            q_vld   <= d_vld;
            q_data  <= shifted;
            q_shamt <= d_shamt;
            q_dir   <= d_dir;
            q_arith <= d_arith;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Variable-amount left / logical-right / arithmetic-right shifter, one
// register stage per shift-amount bit, with global valid/ready stall.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = stage_count(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_vld,
    output logic          up_rdy,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    input  logic          up_dir,
    input  logic          up_arith,
    output logic          down_vld,
    input  logic          down_rdy,
    output logic [N-1:0]  down_data
);

    logic                    en;
    logic [SW:0]             vld_pipe;
    logic [SW:0][N-1:0]      data_pipe;
    logic [SW:0][SW-1:0]     shamt_pipe;
    logic [SW:0]             arith_pipe;
    shift_dir_t              dir_pipe [SW:0];

    // An empty output slot always lets the pipe advance, even if down_rdy=0.
    assign en     = down_rdy || !down_vld;
    assign up_rdy = en;

    assign vld_pipe[0]   = up_vld;
    assign data_pipe[0]  = up_data;
    assign shamt_pipe[0] = up_shamt;
    assign dir_pipe[0]   = shift_dir_t'(up_dir);
    assign arith_pipe[0] = up_arith;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        barrel_shift_stage #(.N(N), .SW(SW), .K(k)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .d_vld   (vld_pipe[k]),
            .d_data  (data_pipe[k]),
            .d_shamt (shamt_pipe[k]),
            .d_dir   (dir_pipe[k]),
            .d_arith (arith_pipe[k]),
            .q_vld   (vld_pipe[k+1]),
            .q_data  (data_pipe[k+1]),
            .q_shamt (shamt_pipe[k+1]),
            .q_dir   (dir_pipe[k+1]),
            .q_arith (arith_pipe[k+1])
        );
    end

    assign down_vld  = vld_pipe[SW];
    assign down_data = data_pipe[SW];

    logic unused_tail;
    assign unused_tail = ^{shamt_pipe[SW], dir_pipe[SW], arith_pipe[SW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomized and directed bench for pipelined_barrel_shifter against a queue-based reference model.
module tb_pipelined_barrel_shifter;

    localparam int N  = 8;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          up_vld = 1'b0;
    logic          up_rdy;
    logic [N-1:0]  up_data = '0;
    logic [SW-1:0] up_shamt = '0;
    logic          up_dir = 1'b0;
    logic          up_arith = 1'b0;
    logic          down_vld;
    logic          down_rdy = 1'b1;
    logic [N-1:0]  down_data;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_vld    (up_vld),
        .up_rdy    (up_rdy),
        .up_data   (up_data),
        .up_shamt  (up_shamt),
        .up_dir    (up_dir),
        .up_arith  (up_arith),
        .down_vld  (down_vld),
        .down_rdy  (down_rdy),
        .down_data (down_data)
    );

    typedef struct {
        logic [N-1:0] exp;
        int           cyc;
        int           stl;
    } item_t;

    item_t q[$];
    int checks = 0, fails = 0, cyc = 0, stl = 0, outs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] a, input int s,
                                           input logic dir, input logic arith);
        if (!dir) return N'(a << s);
        if (arith) return N'($signed(a) >>> s);
        return N'(a >> s);
    endfunction

    task automatic drive(input logic v, input logic [N-1:0] d, input logic [SW-1:0] s,
                         input logic dir, input logic ar);
        up_vld = v; up_data = d; up_shamt = s; up_dir = dir; up_arith = ar;
    endtask

    // Called at a negedge with inputs set; observes, updates model, advances one cycle.
    task automatic tick();
        logic  stalled;
        item_t it;
        #1;
        stalled = down_vld && !down_rdy;
        chk("up_rdy", {31'd0, up_rdy}, {31'd0, down_rdy || !down_vld});
        if (down_vld && down_rdy) begin
            outs++;
            if (q.size() == 0) chk("spurious_vld", {31'd0, down_vld}, 32'd0);
            else begin
                it = q.pop_front();
                chk("data", {24'd0, down_data}, {24'd0, it.exp});
                chk("latency", (cyc - it.cyc) - (stl - it.stl), SW);
            end
        end
        if (up_vld && up_rdy) begin
            it.exp = model(up_data, int'(up_shamt), up_dir, up_arith);
            it.cyc = cyc;
            it.stl = stl;
            q.push_back(it);
        end
        if (stalled) stl++;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input logic [N-1:0] d, input logic [SW-1:0] s, input logic dir,
                            input logic ar, input logic [N-1:0] exp);
        drive(1'b1, d, s, dir, ar);
        tick();
        up_vld = 1'b0;
        tick();
        tick();
        chk("dir_vld", {31'd0, down_vld}, 32'd1);
        chk("dir_data", {24'd0, down_data}, {24'd0, exp});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        logic [N-1:0] held;

        repeat (2) @(negedge clk);
        chk("rst_vld", {31'd0, down_vld}, 32'd0);
        chk("rst_data", {24'd0, down_data}, 32'd0);
        chk("rst_up_rdy", {31'd0, up_rdy}, 32'd1);
        rst_n = 1'b1;
        tick();

        directed(8'b1011_0011, 3'd3, 1'b0, 1'b0, 8'b1001_1000);
        directed(8'b1011_0011, 3'd3, 1'b1, 1'b0, 8'b0001_0110);
        directed(8'b1011_0011, 3'd3, 1'b1, 1'b1, 8'b1111_0110);
        directed(8'b0111_0000, 3'd7, 1'b1, 1'b1, 8'b0000_0000);
        directed(8'hA5, 3'd0, 1'b0, 1'b0, 8'hA5);
        directed(8'hA5, 3'd0, 1'b1, 1'b0, 8'hA5);
        directed(8'hA5, 3'd0, 1'b1, 1'b1, 8'hA5);
        directed(8'h81, 3'd1, 1'b0, 1'b1, 8'h02);

        // back-to-back: 20 transfers, 20 results over 23 cycles means no gaps
        o0 = outs;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, N'($urandom), SW'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        up_vld = 1'b0;
        repeat (3) tick();
        chk("b2b_count", outs - o0, 20);
        chk("b2b_empty", q.size(), 0);

        // fill with consumer stalled, then hold 5 cycles
        down_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, N'($urandom), SW'($urandom), 1'b1, 1'b1);
            tick();
        end
        drive(1'b1, 8'hC3, 3'd2, 1'b1, 1'b1);
        held = down_data;
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", {31'd0, down_vld}, 32'd1);
            chk("stall_rdy", {31'd0, up_rdy}, 32'd0);
            chk("stall_hold", {24'd0, down_data}, {24'd0, held});
            tick();
        end
        down_rdy = 1'b1;
        o0 = outs;
        tick();
        up_vld = 1'b0;
        tick();
        tick();
        chk("release_count", outs - o0, 3);
        repeat (3) tick();
        chk("release_empty", q.size(), 0);

        // reset with one result at the output and two more in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, N'($urandom), SW'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        up_vld = 1'b0;
        chk("pre_rst_vld", {31'd0, down_vld}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vld", {31'd0, down_vld}, 32'd0);
        chk("async_rst_data", {24'd0, down_data}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        directed(8'h5A, 3'd2, 1'b0, 1'b0, 8'h68);

        // random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            down_rdy = ($urandom_range(0, 3) != 0);
            drive(1'($urandom), N'($urandom), SW'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        down_rdy = 1'b1;
        up_vld = 1'b0;
        repeat (4) tick();
        chk("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Pipelined variable-amount shifter; the runtime-amount, registered counterpart of the fixed-S combinational shifters in the arithmetic/pipelining set.
- Shifts left, logical right or arithmetic right by a per-transaction amount.
- One stage per shift-amount bit, with valid/ready flow control on both sides.
- Sits between any valid/ready producer and consumer in the arithmetic datapath.

Parameters:
- N, 8, data width; must be a power of two, N >= 2.
- SW, $clog2(N), shift-amount width; derived, never overridden.

Ports:
- clk  input  1  clock; all flops on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- up_vld  input  1  upstream transaction valid.
- up_rdy  output  1  shifter can accept a transaction this cycle.
- up_data  input  N  operand, unsigned (signed when up_arith=1).
- up_shamt  input  SW  shift amount, 0..N-1.
- up_dir  input  1  0 = left, 1 = right.
- up_arith  input  1  right shift only: 1 = sign-fill, 0 = zero-fill; ignored for left.
- down_vld  output  1  result valid.
- down_rdy  input  1  downstream accepts result.
- down_data  output  N  shifted result.

Behaviour:
- Reset (rst_n=0, async) clears all stage valids, down_vld and down_data to 0. All data/control stage registers reset to 0. up_rdy follows its combinational rule.
- Pipeline: SW register stages.
  - Stage k (k = 0..SW-1) shifts its input by 2^k when shamt bit k = 1; otherwise it passes the input through.
  - Each stage carries data, shamt, dir, arith and a valid bit.
  - Last-stage registers drive down_data and down_vld.
- Fill rule:
  - Left: zeros fill the LSBs.
  - Right logical: zeros fill the MSBs.
  - Right arithmetic: the current MSB of the stage input fills the vacated bits. The MSB is constant across stages, so the result equals $signed(a) >>> shamt.
- Global advance: en = down_rdy || !down_vld. up_rdy = en.
- When en=1, every stage loads from its predecessor. Stage 0 loads {up_data, up_shamt, up_dir, up_arith, up_vld}.
- When en=0, all stages hold. down_vld and down_data stay stable until accepted.
- A transfer occurs on a clock edge where up_vld && up_rdy. Bubbles (up_vld=0 while en=1) propagate as valid=0; they are not collapsed.
- Latency: SW cycles from accepted input to down_vld with no stall (3 for N=8).
- Throughput: one transaction per cycle while down_rdy=1.
- Simultaneous events:
  - Accept and output in the same cycle are allowed. Output retires and input enters on the same edge.
  - down_rdy=0 with down_vld=0 still advances, so a stalled consumer never blocks an empty output stage.
- up_data, up_shamt, up_dir and up_arith are sampled only on a transfer. When up_vld=0 they are don't-care, but stage 0 data still loads them. Only valid marks results meaningful.
- shamt=0: result equals input for all modes.
- Reset mid-operation drops all in-flight transactions; down_vld=0 immediately (async). After rst_n rises, the first new result appears SW cycles after its transfer.
- Results match the reference-model expressions exactly:
  - a << s
  - a >> s
  - $signed(a) >>> s
  - all truncated to N bits.

Decomposition:
- Package shifter_pkg: typedef enum logic {SHIFT_LEFT=1'b0, SHIFT_RIGHT=1'b1} shift_dir_t; a helper constant function for the stage count.
- Sub-module barrel_shift_stage #(N, SW, K): one registered stage. Shifts by 2^K, honours en, async active-low reset. Instantiated SW times inside a generate for loop.

Test Plan:
- N=8, up_data=8'b1011_0011, shamt=3, dir=left -> after 3 cycles down_vld=1, down_data=8'b1001_1000.
- Same data, shamt=3, dir=right, arith=0 -> 8'b0001_0110. With arith=1 -> 8'b1111_0110. Data 8'b0111_0000, shamt=7, arith=1 -> 8'b0000_0000.
- shamt=0 in all three modes on data 8'hA5 -> 8'hA5 each.
- Back-to-back 20 random transfers with down_rdy=1 -> one result per cycle, in order, each matching the reference model; no gaps.
- Hold down_rdy=0 for 5 cycles with pipeline full -> up_rdy=0, down_data stable. Release -> 3 queued results emerge on consecutive cycles, none lost or duplicated.
- Assert rst_n=0 mid-stream with 2 transactions in flight -> down_vld drops within the same cycle. After release, the next input appears after exactly 3 cycles and no stale result is emitted.
